// File: rtl/dm_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dm_port_arbiter_if
//   Bundles every signal between the data-memory arbiter, its two
//   requesters and the single-port data memory.
//
//   Requester A (pipeline MEM stage, priority):
//     a_req, a_we, a_addr, a_wdata  -> arbiter
//     a_gnt, a_stall, a_rvalid, a_rdata <- arbiter
//   Requester B (loader / debug port):
//     b_req, b_we, b_addr, b_wdata  -> arbiter
//     b_gnt, b_rvalid, b_rdata      <- arbiter
//   Memory side (1-cycle read latency):
//     mem_en, mem_we, mem_addr, mem_wdata <- arbiter
//     mem_rdata                           -> arbiter
//
//   Modports:
//     slave  - the arbiter's view
//     master - the view of whatever drives requests and models the memory
// ---------------------------------------------------------------------------
interface dm_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_stall;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_stall, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_stall, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// ---------------------------------------------------------------------------
// dm_port_arbiter
//   Shares a single-port data memory (1-cycle read latency) between the
//   pipeline MEM stage (requester A, normally wins) and a loader/debug port
//   (requester B). One access is granted per cycle; read data is routed back
//   to whichever requester owned the memory on the previous cycle. B is
//   protected from starvation by a wait counter that forces a grant once B
//   has waited MAX_WAIT cycles.
//
//   Parameters:
//     AW       address width
//     DW       data width
//     MAX_WAIT cycles B may wait before its grant is forced (1..15)
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, ACTIVE-LOW reset
//     bus    dm_port_arbiter_if.slave (requester A/B and memory signals)
// ---------------------------------------------------------------------------
module dm_port_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  dm_port_arbiter_if.slave   bus
);

  localparam logic [3:0] L_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0]    r_waitCnt;
  logic          r_tagV;
  logic          r_tagOwner;
  logic [DW-1:0] r_aHold;
  logic [DW-1:0] r_bHold;

  logic          w_forceB;
  logic          w_aGnt;
  logic          w_bGnt;
  logic          w_memEn;
  logic          w_memWe;
  logic [AW-1:0] w_memAddr;
  logic [DW-1:0] w_memWdata;
  logic          w_aRvalid;
  logic          w_bRvalid;

  // Grant priority: starved B first, then A, then B. The reset term keeps
  // every grant low while reset is asserted, and releases them the very
  // first cycle reset goes high.
  always_comb begin
    w_forceB = 1'b0;
    w_aGnt   = 1'b0;
    w_bGnt   = 1'b0;
    if (reset) begin
      w_forceB = bus.b_req && (r_waitCnt == L_MAX_WAIT);
      if (w_forceB) begin
        w_bGnt = 1'b1;
      end else if (bus.a_req) begin
        w_aGnt = 1'b1;
      end else if (bus.b_req) begin
        w_bGnt = 1'b1;
      end
    end
  end

  // Memory port mux; an idle port drives zeros so nothing stray reaches it.
  always_comb begin
    w_memEn    = w_aGnt | w_bGnt;
    w_memWe    = 1'b0;
    w_memAddr  = '0;
    w_memWdata = '0;
    if (w_aGnt) begin
      w_memWe    = bus.a_we;
      w_memAddr  = bus.a_addr;
      w_memWdata = bus.a_wdata;
    end else if (w_bGnt) begin
      w_memWe    = bus.b_we;
      w_memAddr  = bus.b_addr;
      w_memWdata = bus.b_wdata;
    end
  end

  // The tag records who issued last cycle's read, so returning data goes
  // only to that owner even under back-to-back accesses.
  assign w_aRvalid = reset & r_tagV & ~r_tagOwner;
  assign w_bRvalid = reset & r_tagV &  r_tagOwner;

  assign bus.a_gnt     = w_aGnt;
  assign bus.b_gnt     = w_bGnt;
  assign bus.a_stall   = reset & bus.a_req & ~w_aGnt;
  assign bus.mem_en    = w_memEn;
  assign bus.mem_we    = w_memWe;
  assign bus.mem_addr  = w_memAddr;
  assign bus.mem_wdata = w_memWdata;
  assign bus.a_rvalid  = w_aRvalid;
  assign bus.b_rvalid  = w_bRvalid;

  // During the valid pulse the memory output passes straight through;
  // otherwise the last returned word is shown from the hold register.
  assign bus.a_rdata = w_aRvalid ? bus.mem_rdata : r_aHold;
  assign bus.b_rdata = w_bRvalid ? bus.mem_rdata : r_bHold;

  // Wait counter only counts cycles in which B is actually left waiting;
  // dropping the request forfeits the accumulated credit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_waitCnt <= 4'd0;
    end else if (!bus.b_req || w_bGnt) begin
      r_waitCnt <= 4'd0;
    end else if (r_waitCnt < L_MAX_WAIT) begin
      r_waitCnt <= r_waitCnt + 4'd1;
    end
  end

  // Clearing the tag in reset discards any read that was in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tagV     <= 1'b0;
      r_tagOwner <= 1'b0;
    end else begin
      r_tagV     <= w_memEn & ~w_memWe;
      r_tagOwner <= w_bGnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_aHold <= '0;
      r_bHold <= '0;
    end else begin
      if (w_aRvalid) begin
        r_aHold <= bus.mem_rdata;
      end
      if (w_bRvalid) begin
        r_bHold <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_port_arbiter
//   Self-checking bench for dm_port_arbiter. A behavioural single-port memory
//   sits on the memory side. Every granted read pushes its expected owner and
//   data (from a shadow copy of memory contents) onto a queue; the read
//   response is popped and compared one cycle later. Grants, stall and the
//   memory port are compared against scripted expectations per cycle.
// ---------------------------------------------------------------------------
module tb_dm_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
  } rdExp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int checkCnt = 0;
  int passCnt  = 0;

  logic   curAReq = 1'b0;
  rdExp_t expQ[$];
  rdExp_t popped;

  logic [DW-1:0] memArray [0:255] = '{1: 16'h1111, 2: 16'h2222, 16: 16'h1234, default: 16'h0000};
  logic [DW-1:0] refMem   [0:255] = '{1: 16'h1111, 2: 16'h2222, 16: 16'h1234, default: 16'h0000};
  logic [DW-1:0] memRdata = '0;

  dm_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dm_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single-port memory model, read-first, one cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) memArray[bus.mem_addr[7:0]] <= bus.mem_wdata;
      memRdata <= memArray[bus.mem_addr[7:0]];
    end
  end
  assign bus.mem_rdata = memRdata;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCnt++;
    if (observed === expected) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic aReq, input logic aWe, input logic [AW-1:0] aAddr,
                               input logic [DW-1:0] aWdata, input logic bReq, input logic bWe,
                               input logic [AW-1:0] bAddr, input logic [DW-1:0] bWdata);
    @(posedge clk);
    #1;
    bus.a_req   = aReq;
    bus.a_we    = aWe;
    bus.a_addr  = aAddr;
    bus.a_wdata = aWdata;
    bus.b_req   = bReq;
    bus.b_we    = bWe;
    bus.b_addr  = bAddr;
    bus.b_wdata = bWdata;
    curAReq     = aReq;
  endtask

  task automatic expectGrant(input string tag, input logic expA, input logic expB);
    @(negedge clk);
    checkOutput({tag, " a_gnt"},   {31'd0, bus.a_gnt},   {31'd0, expA});
    checkOutput({tag, " b_gnt"},   {31'd0, bus.b_gnt},   {31'd0, expB});
    checkOutput({tag, " a_stall"}, {31'd0, bus.a_stall}, {31'd0, curAReq & ~expA});
    checkOutput({tag, " mem_en"},  {31'd0, bus.mem_en},  {31'd0, expA | expB});
    if (!expA && !expB) begin
      checkOutput({tag, " idle mem_we"},    {31'd0, bus.mem_we},    32'd0);
      checkOutput({tag, " idle mem_addr"},  {16'd0, bus.mem_addr},  32'd0);
      checkOutput({tag, " idle mem_wdata"}, {16'd0, bus.mem_wdata}, 32'd0);
    end
  endtask

  // Scoreboard: compare last cycle's expected read response, then record
  // what this cycle's grant should return next cycle.
  always @(negedge clk) begin
    if (!reset) begin
      expQ.delete();
    end else begin
      if (expQ.size() > 0) begin
        popped = expQ.pop_front();
        if (popped.owner) begin
          checkOutput("b_rvalid", {31'd0, bus.b_rvalid}, 32'd1);
          checkOutput("a_rvalid quiet", {31'd0, bus.a_rvalid}, 32'd0);
          checkOutput("b_rdata", {16'd0, bus.b_rdata}, {16'd0, popped.data});
        end else begin
          checkOutput("a_rvalid", {31'd0, bus.a_rvalid}, 32'd1);
          checkOutput("b_rvalid quiet", {31'd0, bus.b_rvalid}, 32'd0);
          checkOutput("a_rdata", {16'd0, bus.a_rdata}, {16'd0, popped.data});
        end
      end else begin
        checkOutput("a_rvalid none", {31'd0, bus.a_rvalid}, 32'd0);
        checkOutput("b_rvalid none", {31'd0, bus.b_rvalid}, 32'd0);
      end
      if (bus.a_gnt) begin
        if (bus.a_we) refMem[bus.a_addr[7:0]] = bus.a_wdata;
        else expQ.push_back('{owner: 1'b0, data: refMem[bus.a_addr[7:0]]});
      end else if (bus.b_gnt) begin
        if (bus.b_we) refMem[bus.b_addr[7:0]] = bus.b_wdata;
        else expQ.push_back('{owner: 1'b1, data: refMem[bus.b_addr[7:0]]});
      end
    end
  end

  initial begin
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    // Reset state
    @(negedge clk);
    checkOutput("rst a_gnt",   {31'd0, bus.a_gnt},   32'd0);
    checkOutput("rst b_gnt",   {31'd0, bus.b_gnt},   32'd0);
    checkOutput("rst mem_en",  {31'd0, bus.mem_en},  32'd0);
    checkOutput("rst a_rdata", {16'd0, bus.a_rdata}, 32'd0);
    checkOutput("rst b_rdata", {16'd0, bus.b_rdata}, 32'd0);
    checkOutput("rst waitCnt", {28'd0, dut.r_waitCnt}, 32'd0);
    #1 reset = 1'b1;

    // A read, B idle
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGrant("t1", 1'b1, 1'b0);
    checkOutput("t1 mem_we",   {31'd0, bus.mem_we},   32'd0);
    checkOutput("t1 mem_addr", {16'd0, bus.mem_addr}, 32'h0010);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGrant("t1 idle", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGrant("t1 idle2", 1'b0, 1'b0);
    checkOutput("t1 a_rdata hold", {16'd0, bus.a_rdata}, 32'h1234);

    // Both requesting continuously: B forced in cycles 4 and 9
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
      expectGrant($sformatf("t2 c%0d", i), !(i == 4 || i == 9), (i == 4 || i == 9));
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGrant("t2 idle", 1'b0, 1'b0);

    // B write, then A reads it back
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0020, 16'hBEEF);
    expectGrant("t3 bwr", 1'b0, 1'b1);
    checkOutput("t3 mem_we",    {31'd0, bus.mem_we},    32'd1);
    checkOutput("t3 mem_wdata", {16'd0, bus.mem_wdata}, 32'hBEEF);
    applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGrant("t3 ard", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGrant("t3 idle", 1'b0, 1'b0);
    checkOutput("t3 a_rdata", {16'd0, bus.a_rdata}, 32'hBEEF);

    // A read then B read back to back; holds persist afterwards
    applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGrant("t5 a", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
    expectGrant("t5 b", 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      expectGrant("t5 idle", 1'b0, 1'b0);
    end
    checkOutput("t5 a_rdata hold", {16'd0, bus.a_rdata}, 32'h1111);
    checkOutput("t5 b_rdata hold", {16'd0, bus.b_rdata}, 32'h2222);

    // B waits 3, drops for 1, then needs 4 more waiting cycles
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0, (k != 3), 1'b0, 16'h0002, 16'h0);
      expectGrant($sformatf("t6 c%0d", k), (k != 8), (k == 8));
    end

    // Reset while a read is in flight
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
    expectGrant("t4 grant", 1'b1, 1'b0);
    #2 reset = 1'b0;
    @(negedge clk);
    checkOutput("t4 a_gnt",    {31'd0, bus.a_gnt},    32'd0);
    checkOutput("t4 b_gnt",    {31'd0, bus.b_gnt},    32'd0);
    checkOutput("t4 a_stall",  {31'd0, bus.a_stall},  32'd0);
    checkOutput("t4 a_rvalid", {31'd0, bus.a_rvalid}, 32'd0);
    checkOutput("t4 b_rvalid", {31'd0, bus.b_rvalid}, 32'd0);
    checkOutput("t4 mem_en",   {31'd0, bus.mem_en},   32'd0);
    checkOutput("t4 mem_we",   {31'd0, bus.mem_we},   32'd0);
    checkOutput("t4 a_rdata",  {16'd0, bus.a_rdata},  32'd0);
    checkOutput("t4 b_rdata",  {16'd0, bus.b_rdata},  32'd0);
    checkOutput("t4 waitCnt",  {28'd0, dut.r_waitCnt}, 32'd0);
    #1;
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    curAReq   = 1'b0;
    reset     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      expectGrant("t4 after", 1'b0, 1'b0);
    end
    checkOutput("t4 a_rdata after", {16'd0, bus.a_rdata}, 32'd0);

    // First cycle after a fresh reset release can be granted
    applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGrant("t7 a", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGrant("t7 idle", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGrant("t7 idle2", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
